// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_rr_arbiter: round-robin owner of the 4x1 2-bit LED mux select, with    |
// | bounded dwell and a registered output lane. Option: MUX_ARB_PRIO0_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mux_rr_arbiter #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] a,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic [1:0] y,
  output logic       y_valid
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [CW-1:0] C_CNT_LOAD = CW'(DWELL - 1);

  state_e        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    grant_q, grant_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    y_q, y_d;
  logic          y_valid_q, y_valid_d;

  logic          win_found;
  logic [1:0]    win_idx;
  logic          grant_end;
  logic          arb_point;

  // Offsets are scanned far-to-near so the nearest requester after last_q
  // overwrites the others; offset 4 wraps to last_q itself (lowest priority).
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    for (int k = 4; k >= 1; k--) begin
      if (req[last_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = last_q + 2'(k);
      end
    end
`ifdef MUX_ARB_PRIO0_EN
    if (req[0]) begin
      win_found = 1'b1;
      win_idx   = 2'd0;
    end
`endif
  end

  assign grant_end = (state_q == GRANT) && (!req[sel_q] || (cnt_q == '0));
  assign arb_point = ((state_q == IDLE) && win_found) || grant_end;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    y_d       = a[{sel_q, 1'b0} +: 2];
    y_valid_d = |grant_q;

    if (arb_point) begin
      if (win_found) begin
        state_d = GRANT;
        grant_d = 4'b0001 << win_idx;
        sel_d   = win_idx;
        last_d  = win_idx;
        cnt_d   = C_CNT_LOAD;
      end else begin
        // sel deliberately holds its last value while idle
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    end else if (state_q == GRANT) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      grant_q   <= 4'b0000;
      sel_q     <= 2'd0;
      y_q       <= 2'd0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mux_rr_arbiter: directed scoreboard bench for three dwell settings.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] a   = 8'h00;

  logic [3:0] g4, g2, g1;
  logic [1:0] s4, s2, s1;
  logic [1:0] y4, y2, y1;
  logic       v4, v2, v1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    int         inst;
    logic [3:0] g;
    logic [1:0] s;
    logic       yv;
    logic [1:0] y;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.DWELL(4), .CW(8)) u_d4 (
    .clk(clk), .rst(rst), .req(req), .a(a),
    .grant(g4), .sel(s4), .y(y4), .y_valid(v4)
  );
  mux_rr_arbiter #(.DWELL(2), .CW(8)) u_d2 (
    .clk(clk), .rst(rst), .req(req), .a(a),
    .grant(g2), .sel(s2), .y(y2), .y_valid(v2)
  );
  mux_rr_arbiter #(.DWELL(1), .CW(8)) u_d1 (
    .clk(clk), .rst(rst), .req(req), .a(a),
    .grant(g1), .sel(s1), .y(y1), .y_valid(v1)
  );

  task automatic chk(input string tag, input string fld, input logic [3:0] obs,
                     input logic [3:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
    end
  endtask

  task automatic push(input string tag, input int inst, input logic [3:0] g,
                      input logic [1:0] s, input logic yv, input logic [1:0] y);
    exp_t e;
    e.tag = tag; e.inst = inst; e.g = g; e.s = s; e.yv = yv; e.y = y;
    sb.push_back(e);
  endtask

  // Advance one edge, then retire every queued expectation against its instance.
  task automatic tick();
    exp_t       e;
    logic [3:0] og;
    logic [1:0] os, oy;
    logic       ov;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.inst)
        4:       begin og = g4; os = s4; oy = y4; ov = v4; end
        2:       begin og = g2; os = s2; oy = y2; ov = v2; end
        default: begin og = g1; os = s1; oy = y1; ov = v1; end
      endcase
      chk(e.tag, "grant",   og,         e.g);
      chk(e.tag, "sel",     {2'b0, os}, {2'b0, e.s});
      chk(e.tag, "y_valid", {3'b0, ov}, {3'b0, e.yv});
      chk(e.tag, "y",       {2'b0, oy}, {2'b0, e.y});
    end
  endtask

  initial begin
    // Reset state on all three instances
    rst = 1'b1;
    push("reset", 4, 4'b0000, 2'd0, 1'b0, 2'b00);
    push("reset", 2, 4'b0000, 2'd0, 1'b0, 2'b00);
    push("reset", 1, 4'b0000, 2'd0, 1'b0, 2'b00);
    tick();
    rst = 1'b0;

`ifndef MUX_ARB_PRIO0_EN
    // Single requester on lane 2, continuous through the dwell reload
    a   = 8'b00_10_00_00;
    req = 4'b0100;
    push("t1_first", 4, 4'b0100, 2'd2, 1'b0, 2'b00);
    tick();
    for (int k = 0; k < 6; k++) begin
      push("t1_hold", 4, 4'b0100, 2'd2, 1'b1, 2'b10);
      tick();
    end
    req = 4'b0000;
    push("t1_end", 4, 4'b0000, 2'd2, 1'b1, 2'b10);
    tick();
    push("t1_idle", 4, 4'b0000, 2'd2, 1'b0, 2'b10);
    tick();

    // All four requesting; lane i carries value i
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a   = 8'b11_10_01_00;
    req = 4'b1111;
    for (int k = 1; k <= 9; k++) begin
      logic [1:0] se, ye;
      se = 2'((k - 1) / 2);
      ye = (k == 1) ? 2'd0 : 2'((k - 2) / 2);
      push("t2_rr_d2", 2, 4'b0001 << se, se, k > 1, ye);
      se = 2'(k - 1);
      ye = (k == 1) ? 2'd0 : 2'(k - 2);
      push("t2_rr_d1", 1, 4'b0001 << se, se, k > 1, ye);
      se = 2'((k - 1) / 4);
      ye = (k == 1) ? 2'd0 : 2'((k - 2) / 4);
      push("t2_rr_d4", 4, 4'b0001 << se, se, k > 1, ye);
      tick();
    end

    // Owner drop handing over to lane 3, then reset mid-grant
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0010;
    push("t3_g1", 4, 4'b0010, 2'd1, 1'b0, 2'b00);
    tick();
    req = 4'b1010;
    push("t3_g2", 4, 4'b0010, 2'd1, 1'b1, 2'b01);
    tick();
    req = 4'b1000;
    push("t3_drop", 4, 4'b1000, 2'd3, 1'b1, 2'b01);
    tick();
    push("t3_hold", 4, 4'b1000, 2'd3, 1'b1, 2'b11);
    tick();
    rst = 1'b1;
    push("t4_rst", 4, 4'b0000, 2'd0, 1'b0, 2'b00);
    tick();
    rst = 1'b0;
    req = 4'b1001;
    push("t4_first", 4, 4'b0001, 2'd0, 1'b0, 2'b00);
    tick();
    push("t4_hold", 4, 4'b0001, 2'd0, 1'b1, 2'b00);
    tick();

    // DWELL=1 with two requesters alternates every cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0011;
    for (int k = 1; k <= 6; k++) begin
      logic [1:0] se, ye;
      se = 2'((k - 1) % 2);
      ye = (k == 1) ? 2'd0 : 2'((k - 2) % 2);
      push("t5_alt", 1, 4'b0001 << se, se, k > 1, ye);
      tick();
    end
`else
    // Lane 0 priority: it keeps winning at every dwell end
    a   = 8'b11_10_01_00;
    req = 4'b0111;
    for (int k = 1; k <= 5; k++) begin
      push("p_hold", 2, 4'b0001, 2'd0, k > 1, 2'b00);
      tick();
    end
    req = 4'b0110;
    begin
      logic [1:0] seq_s [5];
      logic [1:0] seq_y [5];
      seq_s = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1};
      seq_y = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
      for (int k = 0; k < 5; k++) begin
        push("p_rr", 2, 4'b0001 << seq_s[k], seq_s[k], 1'b1, seq_y[k]);
        tick();
      end
    end
`endif

    req = 4'b0000;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 4-way, 2-bit LED mux datapath between four requesters. It owns the mux select, issues one-hot grants, enforces a bounded dwell time per owner and registers the selected lane onto the output bus. It sits between the switch/requester logic and the `mux_4x1_2bit` instance, replacing the static `{sw1, sw0}` select with a scheduled one.

## Interface
Parameters:
- `DWELL`, default 4: maximum consecutive cycles one owner holds the grant; legal range 1..255.
- `CW`, default 8: dwell counter width; must satisfy `DWELL <= 2**CW - 1`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req` input 4: per-requester request; `req[i]` requests lane i.
- `a` input 8: four 2-bit lanes; lane i is `a[2i+1:2i]`.
- `grant` output 4: one-hot grant, registered; all zero when idle.
- `sel` output 2: mux select, registered; equals the encoded index of the current owner.
- `y` output 2: registered selected lane data.
- `y_valid` output 1: `y` holds data from a granted lane.

## Operation
- States: IDLE and GRANT. The 2-bit pointer `last` holds the most recently granted index.
- Arbitration point: any cycle in IDLE with `req != 0`, or any GRANT cycle in which the grant ends.
- Round robin: the winner is the first requester with `req[i]=1`, searching `last+1, last+2, ...` modulo 4.
- On a win:
  - `grant` is set one-hot to the winner.
  - `sel` and `last` are set to the winner index.
  - The dwell counter is loaded with `DWELL-1`.
  - The state moves to GRANT.
- GRANT, each cycle:
  - If `req[sel]=0` or the counter is 0, the grant ends.
  - Otherwise the counter decrements.
- Grant end:
  - If any other requester, or the same one, is requesting, re-arbitrate in the same cycle. The next owner's grant appears on the next edge with no idle gap. The same owner can win again only if no other request is present.
  - If no request is present, go to IDLE: `grant=0` and `sel` holds its value.
- Data path: each edge, `y <= a[2*sel+1 : 2*sel]` using the current registered `sel`. `y_valid <= |grant`.
- `sel` never changes while `grant` is nonzero, except at a grant handover edge.
- A request that drops in IDLE before being sampled is ignored. Requests are level-sensitive and are not latched.

## Timing
- Reset, applied on the edge where `rst=1`:
  - Outputs: `grant=0`, `sel=0`, `y=0`, `y_valid=0`.
  - Internal state: IDLE, counter 0, and `last=3` so that lane 0 wins first.
- Reset mid-grant aborts the grant on that edge. Reset has priority over every other update.
- Latency:
  - `req` sampled high at edge N (in IDLE) gives `grant`/`sel` valid after edge N.
  - The first valid `y` with `y_valid=1` appears after edge N+1.
- Latency for `y`: one cycle from `sel`. `y_valid` follows `grant` by exactly one cycle, including at grant end.
- Maximum grant length with continuous request is `DWELL` cycles. With `DWELL=1`, the grant rotates every cycle.
- Simultaneous requests: the winner is decided purely by the pointer. With all four requesting, the order is 0,1,2,3,0,...

## Configuration
- `MUX_ARB_PRIO0_EN`:
  - When defined, requester 0 is high priority. At every arbitration point `req[0]=1` wins regardless of `last`. Remaining arbitration among 1..3 uses round robin on `last`. Dwell limits still apply to lane 0. If lane 0 re-requests at its dwell end, it is granted again with no gap.
  - When undefined, the arbiter is pure round robin as above.

## Test plan
- Reset then `req=4'b0100`, `a=8'b00_10_00_00`:
  - `grant=4'b0100` and `sel=2` one edge after the request.
  - `y=2'b10` and `y_valid=1` one edge later.
  - With continuous request and `DWELL=4`, the grant re-issues to lane 2 after 4 cycles.
- `req=4'b1111` held, `DWELL=2`: `sel` sequence is 0,0,1,1,2,2,3,3,0 with no cycle of `grant=0`.
- Owner drop: lane 1 granted, `req[1]` falls on grant cycle 2 with `req[3]=1`: the next edge gives `grant=4'b1000` and `sel=3`.
- Reset mid-grant: `rst=1` for one edge during lane 3 ownership gives all outputs 0. A following `req=4'b1001` grants lane 0 first.
- `DWELL=1` with `req=4'b0011`: the grant alternates 0,1,0,1 each cycle, and `y_valid` stays 1 throughout.
- With `MUX_ARB_PRIO0_EN`, `req=4'b0111`, `DWELL=2`: the sequence is 0,0,0,0... Dropping `req[0]` gives lanes 1,2 alternating in round robin.
